pu_stage_controller: RTL and testbench

//  Issuing end of the global_stage protocol that every processing_unit consumes. Sequences one decode round
//  (load -> grow/merge loop -> peel -> result handshake -> context save/restore). It OR-reduces the PE

---
 rtl/pu_stage_controller.sv | 211 +++++++++++++++++++++
 tb/tb_pu_stage_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_stage_controller.sv
// pu_stage_controller
// Issuing side of the global_stage protocol shared by every processing unit.
// Runs one decode round: load, a grow/merge loop, peel, the result handshake
// and, with more than one context, a save/wait/restore turnaround. The PE
// busy/odd flags are OR-reduced to decide when merge has converged and whether
// another growth step is needed. MAX_GROWTH must not exceed 255, so the 8-bit
// growth counter can never wrap.
module pu_stage_controller #(
    parameter int PU_COUNT     = 64,
    parameter int NUM_CONTEXTS = 2,
    parameter int MAX_GROWTH   = 16,
    parameter int MERGE_SETTLE = 3,
    localparam int STAGE_WIDTH = 3,
    localparam int CTX_W       = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   measurement_valid,
    output logic                   measurement_ready,
    input  logic [PU_COUNT-1:0]    busy_in,
    input  logic [PU_COUNT-1:0]    odd_in,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   local_context_switch,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [7:0]             growth_count,
    output logic                   overflow,
    output logic [CTX_W-1:0]       context_id
);

    // Stage codes broadcast to the PEs.
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;
    localparam logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM       = 3'd7;

    // Merge settle counter is wide enough to hold MERGE_SETTLE itself.
    localparam int               MCNT_W         = (MERGE_SETTLE < 1) ? 1 : $clog2(MERGE_SETTLE + 1);
    localparam logic [MCNT_W-1:0] MERGE_SETTLE_C = MCNT_W'(MERGE_SETTLE);
    localparam logic [7:0]        MAX_GROWTH_C   = 8'(MAX_GROWTH);
    localparam logic [CTX_W-1:0]  CTX_LAST       = CTX_W'(NUM_CONTEXTS - 1);
    localparam bit                HAS_CONTEXTS   = (NUM_CONTEXTS > 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_GROW,
        ST_PEEL,
        ST_RESULT,
        ST_SAVE,
        ST_WAIT,
        ST_RESTORE
    } state_e;

    state_e                 state_q, state_d;
    logic                   load_done_q, load_done_d;
    logic [MCNT_W-1:0]      merge_cnt_q, merge_cnt_d;
    logic [7:0]             growth_q, growth_d;
    logic                   overflow_q, overflow_d;
    logic [CTX_W-1:0]       ctx_q, ctx_d;
    logic [STAGE_WIDTH-1:0] stage_q, stage_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;

    logic any_busy;
    logic any_odd;
    logic settled;

    // Stage code that the PEs must see while the controller sits in a state.
    function automatic logic [STAGE_WIDTH-1:0] stage_of(input state_e s);
        logic [STAGE_WIDTH-1:0] code;
        code = STAGE_IDLE;
        unique case (s)
            ST_IDLE:    code = STAGE_IDLE;
            ST_LOAD:    code = STAGE_MEASUREMENT_LOADING;
            ST_MERGE:   code = STAGE_MERGE;
            ST_GROW:    code = STAGE_GROW;
            ST_PEEL:    code = STAGE_PEELING;
            ST_RESULT:  code = STAGE_RESULT_VALID;
            ST_SAVE:    code = STAGE_WRITE_TO_MEM;
            ST_WAIT:    code = STAGE_IDLE;
            ST_RESTORE: code = STAGE_READ_FROM_MEM;
            default:    code = STAGE_IDLE;
        endcase
        return code;
    endfunction

    // Cluster-wide flags: any PE still busy, any PE still holding an odd cluster.
    assign any_busy = |busy_in;
    assign any_odd  = |odd_in;
    assign settled  = (merge_cnt_q == MERGE_SETTLE_C);

    // Next-state and round bookkeeping for the decode sequence.
    always_comb begin
        // NOTE: every _d signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        load_done_d = 1'b0;
        merge_cnt_d = '0;
        growth_d    = growth_q;
        overflow_d  = overflow_q;
        ctx_d       = ctx_q;

        unique case (state_q)
            ST_IDLE: begin
                // ready is high throughout IDLE, so valid alone completes the handshake.
                if (measurement_valid) begin
                    state_d    = ST_LOAD;
                    growth_d   = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_LOAD: begin
                // Two cycles: the first arms load_done, the second moves on.
                if (load_done_q) begin
                    state_d = ST_MERGE;
                end else begin
                    load_done_d = 1'b1;
                end
            end

            ST_MERGE: begin
                // Flags are stale until the stage register, PE compute and PE busy register have all turned over.
                if (!settled) begin
                    merge_cnt_d = merge_cnt_q + 1'b1;
                end else if (any_busy) begin
                    merge_cnt_d = merge_cnt_q;
                end else if (any_odd && (growth_q < MAX_GROWTH_C)) begin
                    state_d  = ST_GROW;
                    growth_d = growth_q + 8'd1;
                end else begin
                    state_d = ST_PEEL;
                    if (any_odd) begin
                        overflow_d = 1'b1;
                    end
                end
            end

            // Always a single cycle and always followed by MERGE, so GROW steps never abut.
            ST_GROW: state_d = ST_MERGE;

            ST_PEEL: state_d = ST_RESULT;

            ST_RESULT: begin
                if (result_ready) begin
                    state_d = HAS_CONTEXTS ? ST_SAVE : ST_IDLE;
                end
            end

            ST_SAVE: state_d = ST_WAIT;

            // Gives the PE RAM one cycle of read latency before the restore.
            ST_WAIT: state_d = ST_RESTORE;

            ST_RESTORE: begin
                state_d = ST_IDLE;
                ctx_d   = (ctx_q == CTX_LAST) ? '0 : ctx_q + 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs follow the next state so they line up with state_q.
    always_comb begin
        stage_d = stage_of(state_d);
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESULT);
    end

    // State and output registers; reset aborts a round on the spot.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from values sampled before the edge.
        if (reset) begin
            state_q     <= ST_IDLE;
            load_done_q <= 1'b0;
            merge_cnt_q <= '0;
            growth_q    <= '0;
            overflow_q  <= 1'b0;
            ctx_q       <= '0;
            stage_q     <= STAGE_IDLE;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= load_done_d;
            merge_cnt_q <= merge_cnt_d;
            growth_q    <= growth_d;
            overflow_q  <= overflow_d;
            ctx_q       <= ctx_d;
            stage_q     <= stage_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
        end
    end

    assign global_stage         = stage_q;
    assign measurement_ready    = ready_q;
    assign result_valid         = valid_q;
    assign growth_count         = growth_q;
    assign overflow             = overflow_q;
    assign context_id           = ctx_q;
    // Only global context switches are issued from here.
    assign local_context_switch = 1'b0;

endmodule

// File: tb/tb_pu_stage_controller.sv
// tb_pu_stage_controller
// Directed rounds against pu_stage_controller with MAX_GROWTH=4 and two
// contexts. Expected stage traces and round results are queued when each
// round is launched and consumed cycle by cycle as the controller runs.
module tb_pu_stage_controller;

    localparam int PU_COUNT = 64;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_GROW   = 3'd2;
    localparam logic [2:0] S_MERGE  = 3'd3;
    localparam logic [2:0] S_PEEL   = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;
    localparam logic [2:0] S_SAVE   = 3'd6;
    localparam logic [2:0] S_READ   = 3'd7;

    typedef struct packed {
        logic [7:0] growth;
        logic       ovf;
        logic       ctx;
    } res_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                measurement_valid;
    logic                measurement_ready;
    logic [PU_COUNT-1:0] busy_in;
    logic [PU_COUNT-1:0] odd_in;
    logic [2:0]          global_stage;
    logic                local_context_switch;
    logic                result_valid;
    logic                result_ready;
    logic [7:0]          growth_count;
    logic                overflow;
    logic [0:0]          context_id;

    int   checks = 0;
    int   errors = 0;
    logic rv_seen = 1'b0;

    logic [2:0] exp_stage_q[$];
    res_t       exp_res_q[$];

    always #5 clk = ~clk;

    pu_stage_controller #(
        .PU_COUNT    (PU_COUNT),
        .NUM_CONTEXTS(2),
        .MAX_GROWTH  (4),
        .MERGE_SETTLE(3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .measurement_valid   (measurement_valid),
        .measurement_ready   (measurement_ready),
        .busy_in             (busy_in),
        .odd_in              (odd_in),
        .global_stage        (global_stage),
        .local_context_switch(local_context_switch),
        .result_valid        (result_valid),
        .result_ready        (result_ready),
        .growth_count        (growth_count),
        .overflow            (overflow),
        .context_id          (context_id)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic res_t mk_res(input logic [7:0] g, input logic o, input logic c);
        res_t r;
        r.growth = g;
        r.ovf    = o;
        r.ctx    = c;
        return r;
    endfunction

    task automatic push_stage(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) exp_stage_q.push_back(s);
    endtask

    // LOAD x2, then grows x (MERGE x4, GROW), a final MERGE phase, PEEL and RESULT.
    task automatic push_round(input int grows, input int last_merge, input int result_cycles);
        push_stage(S_LOAD, 2);
        for (int g = 0; g < grows; g++) begin
            push_stage(S_MERGE, 4);
            push_stage(S_GROW, 1);
        end
        push_stage(S_MERGE, last_merge);
        push_stage(S_PEEL, 1);
        push_stage(S_RESULT, result_cycles);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, inputs change there too.
    task automatic cyc();
        logic [2:0] s;
        res_t       r;
        @(posedge clk);
        #1;
        if (exp_stage_q.size() != 0) begin
            s = exp_stage_q.pop_front();
            check("global_stage", 32'(global_stage), 32'(s));
        end
        if (result_valid && !rv_seen) begin
            check("result_expected", 32'(result_valid), 32'(exp_res_q.size() != 0));
            if (exp_res_q.size() != 0) begin
                r = exp_res_q.pop_front();
                check("growth_count", 32'(growth_count), 32'(r.growth));
                check("overflow", 32'(overflow), 32'(r.ovf));
                check("context_id_result", 32'(context_id), 32'(r.ctx));
            end
        end
        rv_seen = result_valid;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stage"}, 32'(global_stage), 32'(S_IDLE));
        check({tag, "_ready"}, 32'(measurement_ready), 32'd1);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_growth"}, 32'(growth_count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_ctx"}, 32'(context_id), 32'd0);
        check({tag, "_lcs"}, 32'(local_context_switch), 32'd0);
    endtask

    // Called in the cycle whose end edge accepts the result (result_ready already driven).
    task automatic handshake_tail(input logic exp_ctx);
        push_stage(S_SAVE, 1);
        push_stage(S_IDLE, 1);
        push_stage(S_READ, 1);
        push_stage(S_IDLE, 1);
        cyc();
        result_ready = 1'b0;
        check("valid_after_accept", 32'(result_valid), 32'd0);
        cyc();
        check("ready_in_wait", 32'(measurement_ready), 32'd0);
        cyc();
        cyc();
        check("ready_after_round", 32'(measurement_ready), 32'd1);
        check("context_id_after_round", 32'(context_id), 32'(exp_ctx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // NOTE: inputs are driven with blocking assignments 1 unit after the edge, so the DUT never races them.
        reset             = 1'b1;
        measurement_valid = 1'b0;
        busy_in           = '0;
        odd_in            = '0;
        result_ready      = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        check_reset_outputs("reset");
        push_stage(S_IDLE, 1);
        cyc();

        // Round 1: no odd clusters; valid held through LOAD must not restart the round.
        measurement_valid = 1'b1;
        push_round(0, 4, 1);
        exp_res_q.push_back(mk_res(8'd0, 1'b0, 1'b0));
        cyc();
        cyc();
        measurement_valid = 1'b0;
        repeat (6) cyc();
        result_ready = 1'b1;
        handshake_tail(1'b1);

        // Round 2: odd for the first two merge phases; stray result_ready before RESULT.
        odd_in[5]         = 1'b1;
        result_ready      = 1'b1;
        measurement_valid = 1'b1;
        push_round(2, 4, 1);
        exp_res_q.push_back(mk_res(8'd2, 1'b0, 1'b1));
        cyc();
        measurement_valid = 1'b0;
        cyc();
        repeat (5) cyc();
        repeat (5) cyc();
        odd_in[5] = 1'b0;
        repeat (4) cyc();
        cyc();
        cyc();
        handshake_tail(1'b0);

        // Round 3: flags during settle ignored, then busy holds MERGE for 10 cycles.
        measurement_valid = 1'b1;
        push_round(0, 14, 1);
        exp_res_q.push_back(mk_res(8'd0, 1'b0, 1'b0));
        cyc();
        measurement_valid = 1'b0;
        cyc();
        for (int m = 1; m <= 14; m++) begin
            cyc();
            busy_in[0] = (m == 2) || ((m >= 4) && (m <= 13));
            odd_in[63] = (m <= 13);
        end
        cyc();
        cyc();
        result_ready = 1'b1;
        handshake_tail(1'b1);

        // Reset while in GROW, context 1 at the time.
        odd_in            = '1;
        measurement_valid = 1'b1;
        push_stage(S_LOAD, 2);
        push_stage(S_MERGE, 4);
        push_stage(S_GROW, 1);
        cyc();
        measurement_valid = 1'b0;
        repeat (6) cyc();
        reset = 1'b1;
        push_stage(S_IDLE, 1);
        cyc();
        reset = 1'b0;
        check_reset_outputs("grow_reset");
        push_stage(S_IDLE, 1);
        cyc();

        // Round 4: odd stuck high -> 4 GROWs, overflow; result_ready withheld for 5 RESULT cycles.
        measurement_valid = 1'b1;
        push_round(4, 4, 5);
        exp_res_q.push_back(mk_res(8'd4, 1'b1, 1'b0));
        cyc();
        measurement_valid = 1'b0;
        cyc();
        repeat (4) repeat (5) cyc();
        repeat (4) cyc();
        cyc();
        for (int h = 0; h < 5; h++) begin
            cyc();
            check("held_valid", 32'(result_valid), 32'd1);
            check("held_growth", 32'(growth_count), 32'd4);
            check("held_overflow", 32'(overflow), 32'd1);
            if (h == 4) result_ready = 1'b1;
        end
        handshake_tail(1'b1);

        // Round 5: overflow round again, reset while RESULT is pending on context 1.
        measurement_valid = 1'b1;
        push_round(4, 4, 1);
        exp_res_q.push_back(mk_res(8'd4, 1'b1, 1'b1));
        cyc();
        measurement_valid = 1'b0;
        cyc();
        repeat (4) repeat (5) cyc();
        repeat (4) cyc();
        cyc();
        cyc();
        reset = 1'b1;
        push_stage(S_IDLE, 1);
        cyc();
        reset  = 1'b0;
        odd_in = '0;
        check_reset_outputs("result_reset");

        // Round 6: clean round after the aborted one.
        measurement_valid = 1'b1;
        push_round(0, 4, 1);
        exp_res_q.push_back(mk_res(8'd0, 1'b0, 1'b0));
        cyc();
        measurement_valid = 1'b0;
        repeat (7) cyc();
        result_ready = 1'b1;
        handshake_tail(1'b1);

        check("stages_left", 32'(exp_stage_q.size()), 32'd0);
        check("results_left", 32'(exp_res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
